// File: rtl/qam_tx_mod_if.sv
// Bit-source handshake and symbol/DAC output bundle of the QAM transmit core.
interface qam_tx_mod_if #(
    parameter int BIT_DAC = 14
);
    logic               in_bit;
    logic               in_valid;
    logic               in_ready;
    logic               sym_strobe;
    logic               underrun;
    logic [BIT_DAC-1:0] dac_i;
    logic [BIT_DAC-1:0] dac_q;

    // Bit producer and DAC consumer side.
    modport master (
        output in_bit, in_valid,
        input  in_ready, sym_strobe, underrun, dac_i, dac_q
    );

    // Transmit core side.
    modport slave (
        input  in_bit, in_valid,
        output in_ready, sym_strobe, underrun, dac_i, dac_q
    );
endinterface

// File: rtl/qam_tx_mod.sv
// M-ary QAM baseband transmitter: collects bits per symbol period, Gray-maps
// them to I/Q levels, shapes them (rectangular or SPS-tap moving average) and
// produces registered offset-binary DAC words.
module qam_tx_mod #(
    parameter int          SPS        = 8,
    parameter int          BIT_DAC    = 14,
    parameter logic [11:0] SEED       = 12'h001,
    parameter logic [12:0] GEN_POLY   = 13'b1_0000_1101_0001,
    parameter int          GAIN_SHIFT = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  mod_sel,
    input  logic        src_sel,
    input  logic        shape_en,
    qam_tx_mod_if.slave bus
);
    localparam int                 CNT_W    = $clog2(SPS);
    localparam int                 ACC_W    = $clog2(7 * SPS) + 2;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SPS - 1);
    localparam logic [BIT_DAC-1:0] DAC_MID  = {1'b1, {(BIT_DAC-1){1'b0}}};

    // Gray code (zero-extended to 3 bits) to symmetric level 2n-(2^m-1).
    function automatic logic signed [3:0] gray_level(input logic [2:0] g, input logic [1:0] m);
        logic [2:0]        n;
        logic [4:0]        span;
        logic signed [4:0] lvl;
        n[2] = g[2];
        n[1] = g[2] ^ g[1];
        n[0] = g[2] ^ g[1] ^ g[0];
        span = (5'd1 << m) - 5'd1;
        lvl  = $signed({1'b0, n, 1'b0}) - $signed(span);
        return lvl[3:0];
    endfunction

    // Scale the accumulator onto the DAC and move to offset binary.
    function automatic logic [BIT_DAC-1:0] to_dac(input logic signed [ACC_W-1:0] acc);
        logic signed [BIT_DAC-1:0] wide;
        wide = BIT_DAC'(acc);
        return (wide <<< GAIN_SHIFT) + DAC_MID;
    endfunction

    logic [CNT_W-1:0]        count;
    logic [2:0]              bit_cnt;
    logic [11:0]             lfsr;
    logic [5:0]              sh;
    logic [1:0]              mod_r;
    logic                    src_r;
    logic                    shape_r;
    logic [1:0]              m_cur;
    logic [2:0]              k_cur;
    logic [2:0]              gi;
    logic [2:0]              gq;
    logic                    boundary;
    logic                    window;
    logic                    take;
    logic                    bit_now;
    logic                    short_sym;
    logic signed [3:0]       lvl_i_p0;
    logic signed [3:0]       lvl_q_p0;
    logic                    vld_p0;
    logic                    under_p0;
    logic signed [3:0]       dl_i_p1 [SPS];
    logic signed [3:0]       dl_q_p1 [SPS];
    logic signed [ACC_W-1:0] ma_i_p1;
    logic signed [ACC_W-1:0] ma_q_p1;
    logic signed [ACC_W-1:0] rect_i_p1;
    logic signed [ACC_W-1:0] rect_q_p1;
    logic [BIT_DAC-1:0]      dac_i_p2;
    logic [BIT_DAC-1:0]      dac_q_p2;

    // Mode decode, collection window and per-axis bit split.
    always_comb begin
        m_cur = 2'd1;
        gi    = 3'b000;
        gq    = 3'b000;
        case (mod_r)
            2'd1: begin
                m_cur = 2'd2;
                gi    = {1'b0, sh[3:2]};
                gq    = {1'b0, sh[1:0]};
            end
            2'd2: begin
                m_cur = 2'd3;
                gi    = sh[5:3];
                gq    = sh[2:0];
            end
            default: begin
                m_cur = 2'd1;
                gi    = {2'b00, sh[1]};
                gq    = {2'b00, sh[0]};
            end
        endcase
        k_cur     = {m_cur, 1'b0};
        boundary  = (count == CNT_LAST);
        short_sym = (bit_cnt < k_cur);
        window    = short_sym && !boundary;
        take      = window && (!src_r || bus.in_valid);
        bit_now   = src_r ? bus.in_bit : lfsr[0];
    end

    // Sample counter, bit collection, PN generator and boundary mode latch.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            bit_cnt <= '0;
            lfsr    <= SEED;
            sh      <= '0;
            mod_r   <= '0;
            src_r   <= 1'b0;
            shape_r <= 1'b0;
        end else begin
            count <= boundary ? '0 : count + CNT_W'(1);
            if (boundary) begin
                bit_cnt <= '0;
                sh      <= '0;
                mod_r   <= mod_sel;
                src_r   <= src_sel;
                shape_r <= shape_en;
            end else if (take) begin
                bit_cnt <= bit_cnt + 3'd1;
                sh      <= {sh[4:0], bit_now};
            end
            if (take && !src_r) begin
                lfsr <= {^(lfsr & GEN_POLY[11:0]), lfsr[11:1]};
            end
        end
    end

    // Symbol latch: complete symbols map to levels, incomplete ones to zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lvl_i_p0 <= '0;
            lvl_q_p0 <= '0;
            vld_p0   <= 1'b0;
            under_p0 <= 1'b0;
        end else begin
            vld_p0   <= boundary;
            under_p0 <= boundary && short_sym;
            if (boundary) begin
                lvl_i_p0 <= short_sym ? 4'sd0 : gray_level(gi, m_cur);
                lvl_q_p0 <= short_sym ? 4'sd0 : gray_level(gq, m_cur);
            end
        end
    end

    // Shaping: rectangular hold and free-running SPS-tap sum over a delay line.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < SPS; j++) begin
                dl_i_p1[j] <= '0;
                dl_q_p1[j] <= '0;
            end
            ma_i_p1   <= '0;
            ma_q_p1   <= '0;
            rect_i_p1 <= '0;
            rect_q_p1 <= '0;
        end else begin
            dl_i_p1[0] <= lvl_i_p0;
            dl_q_p1[0] <= lvl_q_p0;
            for (int j = 1; j < SPS; j++) begin
                dl_i_p1[j] <= dl_i_p1[j-1];
                dl_q_p1[j] <= dl_q_p1[j-1];
            end
            ma_i_p1   <= ma_i_p1 + ACC_W'(lvl_i_p0) - ACC_W'(dl_i_p1[SPS-1]);
            ma_q_p1   <= ma_q_p1 + ACC_W'(lvl_q_p0) - ACC_W'(dl_q_p1[SPS-1]);
            rect_i_p1 <= ACC_W'(lvl_i_p0) <<< CNT_W;
            rect_q_p1 <= ACC_W'(lvl_q_p0) <<< CNT_W;
        end
    end

    // DAC output register; the shape select only picks which accumulator feeds it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dac_i_p2 <= DAC_MID;
            dac_q_p2 <= DAC_MID;
        end else begin
            dac_i_p2 <= to_dac(shape_r ? ma_i_p1 : rect_i_p1);
            dac_q_p2 <= to_dac(shape_r ? ma_q_p1 : rect_q_p1);
        end
    end

    assign bus.in_ready   = src_r && window;
    assign bus.sym_strobe = vld_p0;
    assign bus.underrun   = under_p0;
    assign bus.dac_i      = dac_i_p2;
    assign bus.dac_q      = dac_q_p2;

endmodule

// File: tb/tb_qam_tx_mod.sv
// Directed bench for qam_tx_mod: reset, PN start-up, mode timing, external
// vector table, underrun and moving-average ramp.
module tb_qam_tx_mod;
    localparam int SPS     = 8;
    localparam int BIT_DAC = 14;

    typedef struct {
        logic [1:0]  mod;
        logic [5:0]  bits;      // first transmitted bit at [5]
        int          nvalid;
        logic        exp_under;
        int          exp_rdy;
        logic [13:0] exp_i;
        logic [13:0] exp_q;
    } vec_t;

    logic       clock    = 1'b0;
    logic       reset    = 1'b0;
    logic [1:0] mod_sel  = 2'd0;
    logic       src_sel  = 1'b0;
    logic       shape_en = 1'b0;
    int         n_tests  = 0;
    int         n_fail   = 0;
    vec_t       vecs [8];

    qam_tx_mod_if #(.BIT_DAC(BIT_DAC)) bus ();

    qam_tx_mod #(
        .SPS        (SPS),
        .BIT_DAC    (BIT_DAC),
        .SEED       (12'h001),
        .GEN_POLY   (13'b1_0000_1101_0001),
        .GAIN_SHIFT (7)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .mod_sel  (mod_sel),
        .src_sel  (src_sel),
        .shape_en (shape_en),
        .bus      (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_strobe(input string name, input int limit, output int n);
        n = 0;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clock);
            #1;
            if (bus.sym_strobe === 1'b1) begin
                n = i;
                break;
            end
        end
        if (n == 0) check({name, "_timeout"}, 0, 1);
    endtask

    // Starts in the strobe cycle (count 0); returns #1 after the next latch edge.
    task automatic feed_period(input logic [5:0] bits, input int nvalid, output int rdy);
        int   idx;
        logic acc;
        idx = 0;
        rdy = 0;
        for (int c = 0; c < SPS - 1; c++) begin
            bus.in_valid = (idx < nvalid);
            bus.in_bit   = (idx < 6) ? bits[5 - idx] : 1'b0;
            if (bus.in_ready === 1'b1) rdy++;
            acc = bus.in_valid && (bus.in_ready === 1'b1);
            @(posedge clock);
            #1;
            if (acc) idx++;
        end
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_dac_i"},   bus.dac_i, 8192);
        check({tag, "_dac_q"},   bus.dac_q, 8192);
        check({tag, "_strobe"},  bus.sym_strobe, 0);
        check({tag, "_underrun"}, bus.underrun, 0);
        check({tag, "_in_ready"}, bus.in_ready, 0);
    endtask

    // Called right after reset release at a falling edge, PN/QPSK/rect inputs.
    task automatic first_symbol(input string tag);
        int n;
        wait_strobe({tag, "_sym1"}, 3 * SPS, n);
        check({tag, "_latency"}, n, SPS);
        step(1);
        check({tag, "_dac_i_l1"}, bus.dac_i, 8192);
        step(1);
        check({tag, "_dac_i_l2"}, bus.dac_i, 9216);
        check({tag, "_dac_q_l2"}, bus.dac_q, 7168);
        wait_strobe({tag, "_sym2"}, 3 * SPS, n);
        check({tag, "_period"}, n + 2, SPS);
        step(2);
        check({tag, "_sym2_dac_i"}, bus.dac_i, 7168);
        check({tag, "_sym2_dac_q"}, bus.dac_q, 7168);
    endtask

    initial begin
        int n;
        int rdy;
        bus.in_bit   = 1'b0;
        bus.in_valid = 1'b0;

        vecs[0] = '{2'd2, 6'b100011, 6, 1'b0, 6, 14'd15360, 14'd5120};
        vecs[1] = '{2'd1, 6'b100100, 4, 1'b0, 4, 14'd11264, 14'd7168};
        vecs[2] = '{2'd1, 6'b001100, 4, 1'b0, 4, 14'd5120,  14'd9216};
        vecs[3] = '{2'd0, 6'b010000, 2, 1'b0, 2, 14'd7168,  14'd9216};
        vecs[4] = '{2'd2, 6'b000110, 6, 1'b0, 6, 14'd1024,  14'd9216};
        vecs[5] = '{2'd1, 6'b111000, 3, 1'b1, 7, 14'd8192,  14'd8192};
        vecs[6] = '{2'd3, 6'b110000, 2, 1'b0, 2, 14'd9216,  14'd9216};
        vecs[7] = '{2'd2, 6'b010111, 6, 1'b0, 6, 14'd7168,  14'd11264};

        // Power-on reset and PN start-up.
        step(3);
        check_reset_state("boot_rst");
        @(negedge clock);
        reset = 1'b1;
        first_symbol("boot");

        // Asynchronous reset mid-operation, asserted during a strobe cycle.
        wait_strobe("pre_rst", 3 * SPS, n);
        #2;
        reset = 1'b0;
        #1;
        check_reset_state("mid_rst");
        @(negedge clock);
        reset = 1'b1;
        first_symbol("rerun");

        // Mode change mid-period takes effect only after the next boundary.
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        step(3);
        mod_sel = 2'd1;
        wait_strobe("mode_sym1", 3 * SPS, n);
        check("mode_sym1_latency", n, SPS - 3);
        step(2);
        check("mode_qpsk_dac_i", bus.dac_i, 9216);
        check("mode_qpsk_dac_q", bus.dac_q, 7168);
        wait_strobe("mode_sym2", 3 * SPS, n);
        step(2);
        check("mode_16qam_dac_i", bus.dac_i, 5120);
        check("mode_16qam_dac_q", bus.dac_q, 5120);

        // External source vector table, rectangular shaping.
        for (int v = 0; v < 8; v++) begin
            mod_sel  = vecs[v].mod;
            src_sel  = 1'b1;
            shape_en = 1'b0;
            wait_strobe($sformatf("vec%0d_sync", v), 3 * SPS, n);
            feed_period(vecs[v].bits, vecs[v].nvalid, rdy);
            check($sformatf("vec%0d_strobe", v),   bus.sym_strobe, 1);
            check($sformatf("vec%0d_underrun", v), bus.underrun, vecs[v].exp_under);
            check($sformatf("vec%0d_ready_cnt", v), rdy, vecs[v].exp_rdy);
            step(2);
            check($sformatf("vec%0d_dac_i", v), bus.dac_i, vecs[v].exp_i);
            check($sformatf("vec%0d_dac_q", v), bus.dac_q, vecs[v].exp_q);
        end

        // Moving average: +1,+1 symbols settle, then a -1 symbol ramps down.
        mod_sel  = 2'd0;
        src_sel  = 1'b1;
        shape_en = 1'b1;
        wait_strobe("ma_sync", 3 * SPS, n);
        feed_period(6'b110000, 2, rdy);
        feed_period(6'b110000, 2, rdy);
        feed_period(6'b000000, 2, rdy);
        for (int j = 0; j <= SPS; j++) begin
            step(1);
            check($sformatf("ma_ramp%0d_dac_i", j), bus.dac_i, 9216 - 256 * j);
        end
        check("ma_final_dac_q", bus.dac_q, 7168);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
